// File: rtl/muldiv_seq.sv
// Sequencer for the multicycle multiplier/divider and the Hi/Lo registers.
// Accepts one op at a time from the main control and reports done or an exception.
module muldiv_seq #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       div_end,
  input  logic       div_zero,
  output logic       mult_ctrl,
  output logic       div_ctrl,
  output logic       DIVASelect,
  output logic       DIVBSelect,
  output logic       MDSelect,
  output logic       HiCtrl,
  output logic       LoCtrl,
  output logic       busy,
  output logic       done,
  output logic       excpt_req,
  output logic [1:0] excpt_code
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MULT_RUN = 3'd1;
  localparam logic [2:0] S_DIV_RUN  = 3'd2;
  localparam logic [2:0] S_WRITE_HL = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_EXCPT    = 3'd5;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVM = 2'b10;

  localparam logic [1:0] EXC_ZERO    = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] exc_q, exc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (start && (op == OP_MULT)) begin
          op_d    = op;
          cnt_d   = MULT_LAST;
          state_d = S_MULT_RUN;
        end else if (start && ((op == OP_DIV) || (op == OP_DIVM))) begin
          op_d    = op;
          cnt_d   = 6'd0;
          state_d = S_DIV_RUN;
        end
      end
      S_MULT_RUN: begin
        if (cnt_q == 6'd0) begin
          state_d = S_WRITE_HL;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DIV_RUN: begin
        // div_zero outranks div_end so a faulting divide never writes Hi/Lo
        if (div_zero) begin
          exc_d   = EXC_ZERO;
          state_d = S_EXCPT;
        end else if (div_end) begin
          state_d = S_WRITE_HL;
        end else if (cnt_q == DIV_LAST) begin
          exc_d   = EXC_TIMEOUT;
          state_d = S_EXCPT;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_WRITE_HL: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_EXCPT:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 2'b00;
      exc_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      exc_q   <= exc_d;
    end
  end

  // Moore outputs; reset forces IDLE, so everything reads 0 while reset is low
  assign mult_ctrl  = (state_q == S_MULT_RUN) && (cnt_q == MULT_LAST);
  assign div_ctrl   = (state_q == S_DIV_RUN) && (cnt_q == 6'd0);
  assign DIVASelect = ((state_q == S_DIV_RUN) || (state_q == S_WRITE_HL)) && (op_q == OP_DIVM);
  assign DIVBSelect = DIVASelect;
  assign HiCtrl     = (state_q == S_WRITE_HL);
  assign LoCtrl     = (state_q == S_WRITE_HL);
  assign MDSelect   = (state_q == S_WRITE_HL) && (op_q == OP_MULT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign excpt_req  = (state_q == S_EXCPT);
  assign excpt_code = excpt_req ? exc_q : 2'b00;

endmodule
